// File: rtl/accel_sequencer.sv
// Command sequencer in front of the SPI byte engine: programs the ADXL345 once after reset,
// then bursts through DATAX0..DATAZ1 and publishes X/Y/Z samples atomically.
module accel_sequencer #(
  parameter logic [15:0] STARTUP_CYCLES = 16'd1000,
  parameter logic [23:0] SAMPLE_DIV     = 24'd20000
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] cmd_data,
  output logic        cmd_start,
  input  logic        cmd_done,
  input  logic [7:0]  rx_byte,
  output logic        init_done,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid
);

  typedef enum logic [2:0] {
    STARTUP,
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    COMMIT
  } state_t;

  state_t      state;
  logic [15:0] startup_cnt;
  logic [23:0] timer;
  logic [1:0]  init_idx;
  logic [2:0]  rd_idx;
  logic [7:0]  shadow [6];

  function automatic logic [15:0] init_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'h310B;  // DATA_FORMAT: full resolution, +/-16g
      2'd1:    w = 16'h2C0A;  // BW_RATE: 100 Hz
      default: w = 16'h2D08;  // POWER_CTL: measure
    endcase
    return w;
  endfunction

  function automatic logic [15:0] read_word(input logic [2:0] k);
    logic [5:0] addr;
    addr = 6'h32 + {3'b000, k};
    return {1'b1, 1'b0, addr, 8'h00};
  endfunction

  // Outputs are registered: each ISSUE state is entered with cmd_start already high.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state        <= STARTUP;
      startup_cnt  <= '0;
      timer        <= '0;
      init_idx     <= '0;
      rd_idx       <= '0;
      cmd_data     <= '0;
      cmd_start    <= 1'b0;
      init_done    <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      cmd_start    <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        STARTUP: begin
          if ({1'b0, startup_cnt} + 17'd1 >= {1'b0, STARTUP_CYCLES}) begin
            state     <= INIT_ISSUE;
            init_idx  <= 2'd0;
            cmd_data  <= init_word(2'd0);
            cmd_start <= 1'b1;
          end else begin
            startup_cnt <= startup_cnt + 16'd1;
          end
        end
        INIT_ISSUE: state <= INIT_WAIT;
        INIT_WAIT: begin
          if (cmd_done) begin
            if (init_idx == 2'd2) begin
              init_done <= 1'b1;
              timer     <= '0;
              state     <= IDLE;
            end else begin
              init_idx  <= init_idx + 2'd1;
              cmd_data  <= init_word(init_idx + 2'd1);
              cmd_start <= 1'b1;
              state     <= INIT_ISSUE;
            end
          end
        end
        IDLE: begin
          // Timer saturates at SAMPLE_DIV so a parked sequencer resumes immediately.
          if (timer >= SAMPLE_DIV) begin
            if (enable) begin
              rd_idx    <= 3'd0;
              cmd_data  <= read_word(3'd0);
              cmd_start <= 1'b1;
              state     <= RD_ISSUE;
            end
          end else begin
            timer <= timer + 24'd1;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          if (cmd_done) begin
            shadow[rd_idx] <= rx_byte;
            if (rd_idx == 3'd5) begin
              state <= COMMIT;
            end else begin
              rd_idx    <= rd_idx + 3'd1;
              cmd_data  <= read_word(rd_idx + 3'd1);
              cmd_start <= 1'b1;
              state     <= RD_ISSUE;
            end
          end
        end
        COMMIT: begin
          accel_x      <= {shadow[1], shadow[0]};
          accel_y      <= {shadow[3], shadow[2]};
          accel_z      <= {shadow[5], shadow[4]};
          sample_valid <= 1'b1;
          timer        <= '0;
          state        <= IDLE;
        end
        default: state <= STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Randomized scoreboard bench: a bus-functional SPI engine answers each start after a fixed
// latency with per-burst random bytes; a negedge monitor checks commands and samples.
module tb_accel_sequencer;

  localparam logic [15:0] SC  = 16'd4;
  localparam logic [23:0] SD  = 24'd10;
  localparam int          LAT = 20;

  logic        spi_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] cmd_data;
  logic        cmd_start;
  logic        cmd_done;
  logic [7:0]  rx_byte;
  logic        init_done;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        sample_valid;

  always #5 spi_clk = ~spi_clk;

  accel_sequencer #(
    .STARTUP_CYCLES(SC),
    .SAMPLE_DIV    (SD)
  ) dut (
    .spi_clk     (spi_clk),
    .reset       (reset),
    .enable      (enable),
    .cmd_data    (cmd_data),
    .cmd_start   (cmd_start),
    .cmd_done    (cmd_done),
    .rx_byte     (rx_byte),
    .init_done   (init_done),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .sample_valid(sample_valid)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge spi_clk) cyc <= cyc + 1;

  logic [15:0] cmd_exp [$];
  logic [47:0] smp_exp [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference command stream: three init writes, then read bursts 0x32..0x37 repeating.
  function automatic void load_expect();
    cmd_exp.delete();
    smp_exp.delete();
    cmd_exp.push_back(16'h310B);
    cmd_exp.push_back(16'h2C0A);
    cmd_exp.push_back(16'h2D08);
    for (int b = 0; b < 40; b++)
      for (int k = 0; k < 6; k++)
        cmd_exp.push_back(16'h8000 | ((16'h0032 + 16'(k)) << 8));
  endfunction

  // SPI engine model: done LAT cycles after each start, read data keyed by register address.
  initial begin
    logic [7:0] bytes [6];
    int busy = 0;
    int cnt = 0;
    int m_addr = 0;
    logic m_read = 1'b0;
    int burst_no = 0;
    cmd_done = 1'b0;
    rx_byte  = 8'h00;
    forever begin
      @(posedge spi_clk);
      #2;
      cmd_done = 1'b0;
      if (busy != 0) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          cmd_done = 1'b1;
          if (m_read && m_addr >= 'h32 && m_addr <= 'h37) begin
            rx_byte = bytes[m_addr - 'h32];
            if (m_addr == 'h37)
              smp_exp.push_back({bytes[1], bytes[0], bytes[3], bytes[2], bytes[5], bytes[4]});
          end else begin
            rx_byte = 8'($urandom);
          end
        end
      end else if (cmd_start && !reset) begin
        busy   = 1;
        cnt    = LAT;
        m_read = cmd_data[15];
        m_addr = int'(cmd_data[13:8]);
        if (m_read && m_addr == 'h32) begin
          if (burst_no == 0) begin
            bytes[0] = 8'h34; bytes[1] = 8'h12; bytes[2] = 8'hCD;
            bytes[3] = 8'hAB; bytes[4] = 8'h00; bytes[5] = 8'h80;
          end else begin
            for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
          end
          burst_no++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a command or presents a sample.
  initial begin
    logic        outstanding = 1'b0;
    logic [15:0] last_cmd = '0;
    logic [47:0] held = '0;
    logic        have_sv = 1'b0;
    logic        en_dropped = 1'b0;
    logic        prev_init = 1'b0;
    logic        prev_sv = 1'b0;
    int          sv_cyc = 0;
    int          starts = 0;
    int          last_done_cyc = 0;
    forever begin
      @(negedge spi_clk);
      if (reset) begin
        load_expect();
        outstanding = 1'b0;
        have_sv = 1'b0;
        held = '0;
        starts = 0;
        prev_init = 1'b0;
        prev_sv = 1'b0;
      end else begin
        if (cmd_start) begin
          check("start_while_busy", 64'(outstanding), 64'(0));
          if (cmd_exp.size() == 0) begin
            check("cmd_unexpected", 64'(cmd_data), 64'(0));
          end else begin
            check("cmd_data", 64'(cmd_data), 64'(cmd_exp.pop_front()));
          end
          if (cmd_data == 16'hB200 && have_sv && !en_dropped)
            check("burst_gap", 64'(cyc - sv_cyc), 64'(int'(SD) + 1));
          outstanding = 1'b1;
          last_cmd = cmd_data;
          starts++;
        end else if (outstanding) begin
          check("cmd_hold", 64'(cmd_data), 64'(last_cmd));
        end
        if (cmd_done && outstanding) begin
          outstanding = 1'b0;
          last_done_cyc = cyc;
        end
        if (init_done && !prev_init) begin
          check("init_done_lat", 64'(cyc), 64'(last_done_cyc + 1));
          check("init_starts", 64'(starts), 64'(3));
        end
        prev_init = init_done;
        if (sample_valid) begin
          check("sv_pulse", 64'(prev_sv), 64'(0));
          if (smp_exp.size() == 0) begin
            check("sample_unexpected", 64'({accel_x, accel_y, accel_z}), 64'(0));
          end else begin
            check("sample", 64'({accel_x, accel_y, accel_z}), 64'(smp_exp.pop_front()));
          end
          held = {accel_x, accel_y, accel_z};
          sv_cyc = cyc;
          have_sv = 1'b1;
          en_dropped = 1'b0;
        end else begin
          check("sample_hold", 64'({accel_x, accel_y, accel_z}), 64'(held));
        end
        prev_sv = sample_valid;
        if (!enable) en_dropped = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge spi_clk);
    #3;
  endtask

  // kind 0: init_done high, 1: sample_valid, 2: cmd_start with cmd_data == data
  task automatic wait_event(input int kind, input logic [15:0] data, input int limit,
                            input string name);
    logic found = 1'b0;
    for (int n = 0; n < limit && !found; n++) begin
      tick();
      case (kind)
        0:       found = init_done;
        1:       found = sample_valid;
        default: found = cmd_start && (cmd_data == data);
      endcase
    end
    check(name, 64'(found), 64'(1));
  endtask

  task automatic check_startup(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (n < 50 && !seen) begin
      tick();
      n++;
      if (cmd_start) seen = 1'b1;
      else check({tag, "_quiet"}, 64'({cmd_data, init_done, accel_x, accel_y, accel_z}), 64'(0));
    end
    check({tag, "_start_delay"}, 64'(n), 64'(int'(SC)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd_data"}, 64'(cmd_data), 64'(0));
    check({tag, "_cmd_start"}, 64'(cmd_start), 64'(0));
    check({tag, "_init_done"}, 64'(init_done), 64'(0));
    check({tag, "_accel"}, 64'({accel_x, accel_y, accel_z}), 64'(0));
    check({tag, "_sample_valid"}, 64'(sample_valid), 64'(0));
  endtask

  initial begin
    int n_starts;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    check_startup("boot");

    wait_event(0, 16'h0, 500, "init_done_seen");
    wait_event(1, 16'h0, 1000, "first_sample_seen");
    check("first_x", 64'(accel_x), 64'(16'h1234));
    check("first_y", 64'(accel_y), 64'(16'hABCD));
    check("first_z", 64'(accel_z), 64'(16'h8000));
    repeat (4) wait_event(1, 16'h0, 1000, "periodic_sample");

    // Drop enable during the third read; the burst must still commit, then park.
    wait_event(2, 16'hB400, 1000, "third_read_seen");
    enable = 1'b0;
    wait_event(1, 16'h0, 500, "parked_burst_commit");
    n_starts = 0;
    repeat (1000) begin
      tick();
      if (cmd_start) n_starts++;
    end
    check("parked_quiet", 64'(n_starts), 64'(0));
    enable = 1'b1;
    wait_event(2, 16'hB200, 20, "resume_burst");
    repeat (2) wait_event(1, 16'h0, 1000, "resumed_sample");

    // Reset during the fourth read; the pending done lands in STARTUP and must be ignored.
    wait_event(2, 16'hB500, 1000, "fourth_read_seen");
    repeat (16) tick();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    tick();
    reset = 1'b0;
    check_startup("reboot");
    wait_event(0, 16'h0, 500, "reinit_done_seen");
    repeat (2) wait_event(1, 16'h0, 1000, "post_reset_sample");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
